// File: rtl/bar_pkg.sv
// Shared encodings and constants for the LED bar sequencer.
package bar_pkg;

  localparam int unsigned LED_W = 10;
  localparam int unsigned SSM_W = 4;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_FILL10 = 2'b01,
    MODE_FILL8  = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_DONE  = 2'b10,
    ST_BLINK = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] LIMIT_FILL10 = 4'd10;
  localparam logic [CNT_W-1:0] LIMIT_FILL8  = 4'd8;
  localparam logic [SSM_W-1:0] SSM_BLINK    = 4'hA;
  localparam logic [SSM_W-1:0] SSM_BLANK    = 4'hF;

  function automatic logic [CNT_W-1:0] fill_limit(input mode_e m);
    return (m == MODE_FILL8) ? LIMIT_FILL8 : LIMIT_FILL10;
  endfunction

endpackage

// File: rtl/bar_sequencer_if.sv
// Pushbutton/switch inputs and LED/display outputs of the bar sequencer.
interface bar_sequencer_if;
  import bar_pkg::*;

  logic             start_button;
  logic [1:0]       switch;
  logic [LED_W-1:0] led_out;
  logic [SSM_W-1:0] ssm;
  logic             busy;
  logic             done;

  modport master (
    output start_button, switch,
    input  led_out, ssm, busy, done
  );

  modport slave (
    input  start_button, switch,
    output led_out, ssm, busy, done
  );
endinterface

// File: rtl/tick_prescaler.sv
// Step-tick prescaler with two selectable divisors; held at zero while clr is high.
module tick_prescaler #(
  parameter int unsigned DIV_A = 50000000,
  parameter int unsigned DIV_B = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic sel,
  output logic tick
);
  localparam int unsigned MAX_DIV = (DIV_A > DIV_B) ? DIV_A : DIV_B;
  localparam int unsigned PCNT_W  = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

  logic [PCNT_W-1:0] cnt_q, cnt_d, last_c;

  // tick is a decode of the counter flop so the FSM can use it without a loop through clr
  always_comb begin
    last_c = sel ? PCNT_W'(DIV_B - 1) : PCNT_W'(DIV_A - 1);
    tick   = (cnt_q == last_c);
    cnt_d  = cnt_q + PCNT_W'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/bar_sequencer.sv
// LED bar fill/blink sequencer started by a debounced-free synchronized pushbutton.
module bar_sequencer
  import bar_pkg::*;
#(
  parameter int unsigned SLOW_DIV = 50000000,
  parameter int unsigned FAST_DIV = 25000000
) (
  input  logic           clk,
  input  logic           rst,
  bar_sequencer_if.slave bus
);
  logic       sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic       armed_q, armed_d, start_q, start_d;
  logic [1:0] settle_q, settle_d;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d, sw_c;
  logic [LED_W-1:0] led_q, led_d;
  logic [SSM_W-1:0] ssm_q, ssm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c, limit_c;
  logic             busy_q, busy_d, done_q, done_d;
  logic             enter_c, reload_c, clr_c, sel_c, tick_c;

  // Button only arms after a released level is seen post-reset, so a held button cannot start
  always_comb begin
    sync1_d  = bus.start_button;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | ((settle_q == 2'd2) & sync2_q);
    start_d  = armed_q & sync3_q & ~sync2_q;
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    led_d     = led_q;
    ssm_d     = ssm_q;
    cnt_d     = cnt_q;
    enter_c   = 1'b0;
    reload_c  = 1'b0;
    sw_c      = mode_e'(bus.switch);
    cnt_inc_c = cnt_q + CNT_W'(1);
    limit_c   = fill_limit(mode_q);

    // Priority outside IDLE: abort, then start, then tick
    case (state_q)
      ST_IDLE: begin
        if (start_q && sw_c != MODE_OFF) enter_c = 1'b1;
      end
      default: begin
        if (sw_c == MODE_OFF) begin
          state_d = ST_IDLE;
          led_d   = '0;
          ssm_d   = SSM_BLANK;
          cnt_d   = '0;
        end else if (start_q) begin
          enter_c = 1'b1;
        end else if (tick_c && state_q == ST_FILL) begin
          led_d = {led_q[LED_W-2:0], 1'b1};
          cnt_d = cnt_inc_c;
          ssm_d = limit_c - cnt_inc_c;
          if (cnt_inc_c == limit_c) state_d = ST_DONE;
        end else if (tick_c && state_q == ST_BLINK) begin
          led_d = ~led_q;
        end
      end
    endcase

    if (enter_c) begin
      mode_d   = sw_c;
      reload_c = 1'b1;
      led_d    = '0;
      cnt_d    = '0;
      if (sw_c == MODE_BLINK) begin
        state_d = ST_BLINK;
        ssm_d   = SSM_BLINK;
      end else begin
        state_d = ST_FILL;
        ssm_d   = fill_limit(sw_c);
      end
    end

    busy_d = (state_d == ST_FILL) || (state_d == ST_BLINK);
    done_d = (state_d == ST_DONE);
    clr_c  = reload_c || !busy_d;
  end

  assign sel_c = (mode_q == MODE_FILL8);

  tick_prescaler #(
    .DIV_A (SLOW_DIV),
    .DIV_B (FAST_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_c),
    .sel  (sel_c),
    .tick (tick_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      sync3_q  <= 1'b1;
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
      start_q  <= 1'b0;
      state_q  <= ST_IDLE;
      mode_q   <= MODE_OFF;
      led_q    <= '0;
      ssm_q    <= SSM_BLANK;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sync3_q  <= sync3_d;
      settle_q <= settle_d;
      armed_q  <= armed_d;
      start_q  <= start_d;
      state_q  <= state_d;
      mode_q   <= mode_d;
      led_q    <= led_d;
      ssm_q    <= ssm_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.led_out = led_q;
  assign bus.ssm     = ssm_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_bar_sequencer.sv
// Directed plus randomized checks of bar_sequencer against a closed-form elapsed-time model.
module tb_bar_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bar_sequencer_if bus ();

  bar_sequencer #(
    .SLOW_DIV (4),
    .FAST_DIV (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_led"},  32'(bus.led_out), 32'h0);
    chk({tag, "_ssm"},  32'(bus.ssm),     32'hF);
    chk({tag, "_busy"}, 32'(bus.busy),    32'h0);
    chk({tag, "_done"}, 32'(bus.done),    32'h0);
  endtask

  // Expected outputs t cycles after entering mode m, from step count = t / divisor
  task automatic chk_model(input int m, input int t);
    int div, lim, k, n;
    logic [31:0] e_led, e_ssm, e_busy, e_done;
    div = (m == 2) ? 2 : 4;
    k   = t / div;
    if (m == 3) begin
      e_led  = (k % 2 == 1) ? 32'h3FF : 32'h0;
      e_ssm  = 32'hA;
      e_busy = 32'h1;
      e_done = 32'h0;
    end else begin
      lim    = (m == 2) ? 8 : 10;
      n      = (k < lim) ? k : lim;
      e_led  = (32'h1 << n) - 32'h1;
      e_ssm  = 32'(lim - n);
      e_busy = (n < lim) ? 32'h1 : 32'h0;
      e_done = (n == lim) ? 32'h1 : 32'h0;
    end
    chk($sformatf("m%0d_t%0d_led", m, t),  32'(bus.led_out), e_led);
    chk($sformatf("m%0d_t%0d_ssm", m, t),  32'(bus.ssm),     e_ssm);
    chk($sformatf("m%0d_t%0d_busy", m, t), 32'(bus.busy),    e_busy);
    chk($sformatf("m%0d_t%0d_done", m, t), 32'(bus.done),    e_done);
  endtask

  task automatic observe(input int m, input int t0, input int n);
    for (int i = 0; i < n; i++) begin
      chk_model(m, t0 + i);
      cycle();
    end
  endtask

  // Low on this negedge; the 4th rising edge afterwards is the entry edge
  task automatic press();
    bus.start_button = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start_button = 1'b1;
  endtask

  initial begin
    int m, m2, len;
    rst = 1'b1;
    bus.start_button = 1'b1;
    bus.switch = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    repeat (5) cycle();

    // full slow fill, then DONE re-entered as fast fill
    bus.switch = 2'b01;
    press();
    observe(1, 0, 46);
    bus.switch = 2'b10;
    press();
    observe(2, 0, 20);
    bus.switch = 2'b00;
    cycle();
    chk_idle("done_abort");

    // press with switch off is ignored
    press();
    for (int i = 0; i < 6; i++) begin
      chk_idle("off_press");
      cycle();
    end

    // abort mid-fill at led_out 007
    bus.switch = 2'b01;
    press();
    observe(1, 0, 13);
    chk("mid_fill_led", 32'(bus.led_out), 32'h007);
    bus.switch = 2'b00;
    cycle();
    chk_idle("mid_fill_abort");
    repeat (3) cycle();

    // switch change ignored mid-fill; restarts coincide with a tick edge
    bus.switch = 2'b01;
    press();
    observe(1, 0, 6);
    bus.switch = 2'b11;
    observe(1, 6, 6);
    press();
    observe(3, 0, 12);
    bus.switch = 2'b01;
    press();
    observe(1, 0, 9);
    bus.switch = 2'b00;
    cycle();
    chk_idle("coincide_abort");
    repeat (3) cycle();

    // randomized runs, aborts and restarts
    for (int r = 0; r < 6; r++) begin
      m = int'($urandom_range(1, 3));
      bus.switch = 2'(m);
      press();
      len = int'($urandom_range(3, 50));
      observe(m, 0, len);
      if ($urandom_range(0, 1) == 1) begin
        m2 = int'($urandom_range(1, 3));
        bus.switch = 2'(m2);
        press();
        observe(m2, 0, int'($urandom_range(1, 20)));
      end
      bus.switch = 2'b00;
      cycle();
      chk_idle("rand_abort");
      repeat (3) cycle();
    end

    // reset mid-blink with the button held low
    bus.switch = 2'b11;
    press();
    observe(3, 0, 9);
    bus.start_button = 1'b0;
    rst = 1'b1;
    cycle();
    cycle();
    chk_idle("rst_blink");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk_idle("held_after_rst");
    end
    bus.start_button = 1'b1;
    repeat (4) cycle();
    bus.switch = 2'b01;
    press();
    observe(1, 0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
